// File: rtl/axi_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi_stream_if : byte-lane AXI-Stream bundle (tdata/tvalid/tready/  |
// |                 tlast) with master and slave views.                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface axi_stream_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/tcp_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tcp_receiver : parses Ethernet/IPv4/TCP frames, forwards the TCP   |
// |                payload and flags FCS/checksum/format/length errors.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`ifndef INPUTWIDTH
`define INPUTWIDTH 8
`endif

package tcp_receiver_pkg;
  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq;
    logic [31:0] ack;
    logic [7:0]  flags;
    logic [15:0] window;
    logic [15:0] payload_len;
    logic [15:0] tcp_checksum;
  } tcp_packet_info_s;

  // Reflected Ethernet CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction
endpackage

module tcp_receiver
  import tcp_receiver_pkg::*;
#(
  parameter int DATA_WIDTH = `INPUTWIDTH
) (
  input  logic             clk,
  input  logic             rst,
  axi_stream_if.slave      s_axis,
  axi_stream_if.master     m_axis,
  output tcp_packet_info_s o_pkt,
  output logic             pkt_valid,
  output logic             pkt_err,
  output logic [4:0]       err_flags,
  output logic             busy
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_TAIL    = 3'd3;
  localparam logic [2:0] ST_DROP    = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  logic [2:0]       r_state;
  logic [15:0]      r_cnt;
  logic [31:0]      r_crc;
  logic [31:0]      r_win;
  logic [7:0]       r_hi;
  logic [31:0]      r_ip_sum;
  logic [31:0]      r_tcp_sum;
  logic [15:0]      r_tot;
  logic [16:0]      r_end;
  logic [16:0]      r_min_last;
  logic             r_unsup;
  logic             r_len;
  logic             r_fcs_bad;
  tcp_packet_info_s r_pkt;

  logic [DATA_WIDTH-1:0] w_data;
  logic [7:0]            w_byte;
  logic [15:0]           w_word;
  logic                  w_acc;
  logic                  w_last_pl;
  logic [31:0]           w_crc_nxt;
  logic [31:0]           w_ip_add;
  logic [31:0]           w_tcp_add;
  logic [15:0]           w_plen;
  logic                  w_early;
  logic [4:0]            w_flags;

  function automatic logic [15:0] fold(input logic [31:0] s);
    logic [16:0] a;
    logic [16:0] b;
    a = {1'b0, s[15:0]} + {1'b0, s[31:16]};
    b = {1'b0, a[15:0]} + {16'd0, a[16]};
    return b[15:0];
  endfunction

  assign w_data    = s_axis.tdata;
  assign w_byte    = w_data[7:0];
  assign w_word    = {r_hi, w_byte};
  assign w_acc     = s_axis.tvalid & s_axis.tready;
  assign w_last_pl = ({1'b0, r_cnt} == r_end);
  assign w_crc_nxt = (r_cnt >= 16'd4) ? crc(r_crc, r_win[7:0]) : r_crc;
  assign w_plen    = (r_tot < 16'd40) ? 16'd0 : (r_tot - 16'd40);
  assign w_early   = (r_state == ST_IDLE) || (r_state == ST_HDR) ||
                     ({1'b0, r_cnt} < r_min_last);

  assign w_flags   = {r_len, r_unsup, (fold(r_tcp_sum) != 16'hFFFF),
                      (fold(r_ip_sum) != 16'hFFFF), r_fcs_bad};
  assign pkt_valid = (r_state == ST_DONE) && (w_flags == 5'd0);
  assign pkt_err   = (r_state == ST_DONE) && (w_flags != 5'd0);
  assign err_flags = (r_state == ST_DONE) ? w_flags : 5'd0;
  assign busy      = (r_state != ST_IDLE);
  assign o_pkt     = r_pkt;
  assign m_axis.tdata = w_data;

  always_comb begin
    s_axis.tready = 1'b0;
    m_axis.tvalid = 1'b0;
    m_axis.tlast  = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_PAYLOAD: begin
          s_axis.tready = m_axis.tready;
          m_axis.tvalid = s_axis.tvalid;
          m_axis.tlast  = w_last_pl | s_axis.tlast;
        end
        ST_DONE: s_axis.tready = 1'b0;
        default: s_axis.tready = 1'b1;
      endcase
    end
  end

  // IPv4 header words 14..33; TCP pseudo-header (IPs at 26..33, proto+length
  // folded in at byte 17 as total_length - 20 + 6), TCP header and payload.
  always_comb begin
    w_ip_add  = 32'd0;
    w_tcp_add = 32'd0;
    if (r_state == ST_HDR && r_cnt[0]) begin
      if (r_cnt >= 16'd15 && r_cnt <= 16'd33) w_ip_add = {16'd0, w_word};
      if (r_cnt == 16'd17)      w_tcp_add = {16'd0, w_word} - 32'd14;
      else if (r_cnt >= 16'd27) w_tcp_add = {16'd0, w_word};
    end else if (r_state == ST_PAYLOAD) begin
      if (r_cnt[0])       w_tcp_add = {16'd0, w_word};
      else if (w_last_pl) w_tcp_add = {16'd0, w_byte, 8'h00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 16'd0;
      r_crc      <= 32'hFFFF_FFFF;
      r_win      <= 32'd0;
      r_hi       <= 8'd0;
      r_ip_sum   <= 32'd0;
      r_tcp_sum  <= 32'd0;
      r_tot      <= 16'd0;
      r_end      <= 17'd0;
      r_min_last <= 17'd0;
      r_unsup    <= 1'b0;
      r_len      <= 1'b0;
      r_fcs_bad  <= 1'b0;
      r_pkt      <= '0;
    end else if (r_state == ST_DONE) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 16'd0;
      r_crc     <= 32'hFFFF_FFFF;
      r_win     <= 32'd0;
      r_ip_sum  <= 32'd0;
      r_tcp_sum <= 32'd0;
      r_unsup   <= 1'b0;
      r_len     <= 1'b0;
      r_fcs_bad <= 1'b0;
    end else if (w_acc) begin
      r_cnt     <= r_cnt + 16'd1;
      r_win     <= {w_byte, r_win[31:8]};
      r_crc     <= w_crc_nxt;
      r_ip_sum  <= r_ip_sum + w_ip_add;
      r_tcp_sum <= r_tcp_sum + w_tcp_add;
      if (!r_cnt[0]) r_hi <= w_byte;

      case (r_state)
        ST_IDLE: begin
          r_pkt         <= '0;
          r_pkt.dst_mac <= {40'd0, w_byte};
          r_state       <= ST_HDR;
        end
        ST_HDR: begin
          if (r_cnt <= 16'd5)
            r_pkt.dst_mac <= {r_pkt.dst_mac[39:0], w_byte};
          else if (r_cnt <= 16'd11)
            r_pkt.src_mac <= {r_pkt.src_mac[39:0], w_byte};
          else if (r_cnt >= 16'd26 && r_cnt <= 16'd29)
            r_pkt.src_ip <= {r_pkt.src_ip[23:0], w_byte};
          else if (r_cnt >= 16'd30 && r_cnt <= 16'd33)
            r_pkt.dst_ip <= {r_pkt.dst_ip[23:0], w_byte};
          else if (r_cnt >= 16'd34 && r_cnt <= 16'd35)
            r_pkt.src_port <= {r_pkt.src_port[7:0], w_byte};
          else if (r_cnt >= 16'd36 && r_cnt <= 16'd37)
            r_pkt.dst_port <= {r_pkt.dst_port[7:0], w_byte};
          else if (r_cnt >= 16'd38 && r_cnt <= 16'd41)
            r_pkt.seq <= {r_pkt.seq[23:0], w_byte};
          else if (r_cnt >= 16'd42 && r_cnt <= 16'd45)
            r_pkt.ack <= {r_pkt.ack[23:0], w_byte};
          else if (r_cnt == 16'd47)
            r_pkt.flags <= w_byte;
          else if (r_cnt >= 16'd48 && r_cnt <= 16'd49)
            r_pkt.window <= {r_pkt.window[7:0], w_byte};
          else if (r_cnt >= 16'd50 && r_cnt <= 16'd51)
            r_pkt.tcp_checksum <= {r_pkt.tcp_checksum[7:0], w_byte};

          case (r_cnt)
            16'd13: if (w_word != 16'h0800) r_unsup <= 1'b1;
            16'd14: if (w_byte != 8'h45)    r_unsup <= 1'b1;
            16'd17: begin
              r_tot <= w_word;
              if (w_word < 16'd40) r_len <= 1'b1;
            end
            16'd23: if (w_byte != 8'h06)      r_unsup <= 1'b1;
            16'd46: if (w_byte[7:4] != 4'h5)  r_unsup <= 1'b1;
            16'd53: begin
              r_pkt.payload_len <= w_plen;
              r_end      <= 17'd53 + {1'b0, w_plen};
              r_min_last <= 17'd57 + {1'b0, w_plen};
              if (r_unsup)             r_state <= ST_DROP;
              else if (w_plen != 16'd0) r_state <= ST_PAYLOAD;
              else                      r_state <= ST_TAIL;
            end
            default: ;
          endcase
        end
        ST_PAYLOAD: if (w_last_pl) r_state <= ST_TAIL;
        default: ;
      endcase

      // The window now holds the last four bytes: the FCS, LSB first.
      if (s_axis.tlast) begin
        r_state   <= ST_DONE;
        r_fcs_bad <= ({w_byte, r_win[31:8]} != ~w_crc_nxt);
        if (w_early) r_len <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tcp_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tcp_receiver : table-driven bench for tcp_receiver.             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_tcp_receiver;
  import tcp_receiver_pkg::*;

  typedef struct {
    int          plen;
    logic [7:0]  flags;
    logic [31:0] seq;
    logic [15:0] etype;
    int          cidx;
    logic [7:0]  cxor;
    int          trunc;
    bit          gaps;
    bit          rtog;
    bit          exp_valid;
    logic [4:0]  exp_err;
    logic [4:0]  mask;
    int          beats;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  tcp_packet_info_s o_pkt;
  logic pkt_valid, pkt_err, busy;
  logic [4:0] err_flags;

  axi_stream_if #(.DATA_WIDTH(8)) s_axis ();
  axi_stream_if #(.DATA_WIDTH(8)) m_axis ();

  tcp_receiver #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axis    (s_axis),
    .m_axis    (m_axis),
    .o_pkt     (o_pkt),
    .pkt_valid (pkt_valid),
    .pkt_err   (pkt_err),
    .err_flags (err_flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] fr [0:511];
  int fr_len;
  tcp_packet_info_s exp_pkt;
  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic putb(input logic [7:0] b);
    fr[fr_len] = b;
    fr_len++;
  endtask

  function automatic logic [7:0] pbyte(input int plen, input int k);
    logic [39:0] h;
    h = 40'h48_45_4C_4C_4F;
    if (plen == 5) return h[39-8*k -: 8];
    return 8'((k * 7 + 3) & 255);
  endfunction

  function automatic logic [15:0] csum_fold(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    while (t[31:16] != 16'd0) t = {16'd0, t[15:0]} + {16'd0, t[31:16]};
    return ~t[15:0];
  endfunction

  task automatic build(input vec_t v);
    logic [31:0] s, c;
    logic [15:0] ck, tl;
    tl = 16'(40 + v.plen);
    exp_pkt = '{dst_mac: 48'h0011_2233_4455, src_mac: 48'h6677_8899_AABB,
                src_ip: 32'hC0A8_0001, dst_ip: 32'hC0A8_0002,
                src_port: 16'h04D2, dst_port: 16'h0050, seq: v.seq,
                ack: 32'h0000_2000, flags: v.flags, window: 16'h4000,
                payload_len: 16'(v.plen), tcp_checksum: 16'h0};
    fr_len = 0;
    for (int i = 5; i >= 0; i--) putb(exp_pkt.dst_mac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) putb(exp_pkt.src_mac[8*i +: 8]);
    putb(v.etype[15:8]); putb(v.etype[7:0]);
    putb(8'h45); putb(8'h00); putb(tl[15:8]); putb(tl[7:0]);
    putb(8'h00); putb(8'h01); putb(8'h40); putb(8'h00);
    putb(8'h40); putb(8'h06); putb(8'h00); putb(8'h00);
    for (int i = 3; i >= 0; i--) putb(exp_pkt.src_ip[8*i +: 8]);
    for (int i = 3; i >= 0; i--) putb(exp_pkt.dst_ip[8*i +: 8]);
    putb(8'h04); putb(8'hD2); putb(8'h00); putb(8'h50);
    for (int i = 3; i >= 0; i--) putb(v.seq[8*i +: 8]);
    for (int i = 3; i >= 0; i--) putb(exp_pkt.ack[8*i +: 8]);
    putb(8'h50); putb(v.flags); putb(8'h40); putb(8'h00);
    putb(8'h00); putb(8'h00); putb(8'h00); putb(8'h00);
    for (int k = 0; k < v.plen; k++) putb(pbyte(v.plen, k));
    s = 0;
    for (int i = 14; i < 34; i += 2) s += {16'd0, fr[i], fr[i+1]};
    ck = csum_fold(s);
    fr[24] = ck[15:8]; fr[25] = ck[7:0];
    s = 32'hC0A8 + 32'h0001 + 32'hC0A8 + 32'h0002 + 32'd6 + 32'(20 + v.plen);
    for (int i = 34; i < 54 + v.plen; i += 2)
      s += {16'd0, fr[i], ((i + 1 < 54 + v.plen) ? fr[i+1] : 8'h00)};
    ck = csum_fold(s);
    fr[50] = ck[15:8]; fr[51] = ck[7:0];
    exp_pkt.tcp_checksum = ck;
    while (fr_len < 60) putb(8'h00);
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < fr_len; i++) begin
      c ^= {24'd0, fr[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) putb(c[8*i +: 8]);
    if (v.cidx >= 0) fr[v.cidx] ^= v.cxor;
    if (v.trunc > 0) fr_len = v.trunc;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int idx = 0, nv = 0, ne = 0, nb = 0, ntl = 0, cyc = 0;
    bit done = 0, data_bad = 0, tl_bad = 0;
    logic [4:0] seen = 5'd0;
    while (!done && cyc < 3000) begin
      if (idx < fr_len && (!v.gaps || $urandom_range(0, 3) != 0)) begin
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = fr[idx];
        s_axis.tlast  = (idx == fr_len - 1);
      end else begin
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = 8'($urandom);
        s_axis.tlast  = 1'($urandom);
      end
      m_axis.tready = v.rtog ? (cyc % 2 == 1) : 1'b1;
      #1;
      if (s_axis.tvalid && s_axis.tready) idx++;
      if (m_axis.tvalid && m_axis.tready) begin
        if (nb >= v.beats || m_axis.tdata !== fr[54 + nb]) data_bad = 1;
        if (m_axis.tlast) begin
          ntl++;
          if (nb != v.beats - 1) tl_bad = 1;
        end
        nb++;
      end
      if (pkt_valid) nv++;
      if (pkt_err) ne++;
      if (pkt_valid || pkt_err) begin
        seen = err_flags;
        done = 1;
      end
      @(negedge clk);
      cyc++;
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    m_axis.tready = 1'b1;
    repeat (3) begin
      #1;
      if (pkt_valid) nv++;
      if (pkt_err) ne++;
      @(negedge clk);
    end
    chk({tag, " completion"}, 64'(done), 64'd1);
    chk({tag, " pkt_valid count"}, 64'(nv), 64'(v.exp_valid));
    chk({tag, " pkt_err count"}, 64'(ne), 64'(!v.exp_valid));
    chk({tag, " err_flags"}, 64'(seen & v.mask), 64'(v.exp_err & v.mask));
    chk({tag, " m_axis beats"}, 64'(nb), 64'(v.beats));
    chk({tag, " m_axis data"}, 64'(data_bad), 64'd0);
    if (v.beats > 0) begin
      chk({tag, " tlast count"}, 64'(ntl), 64'd1);
      chk({tag, " tlast position"}, 64'(tl_bad), 64'd0);
    end
    chk({tag, " busy after"}, 64'(busy), 64'd0);
    if (v.exp_valid) begin
      checks++;
      if (o_pkt !== exp_pkt) begin
        errors++;
        $display("FAIL %s o_pkt: got %h expected %h", tag, o_pkt, exp_pkt);
      end
    end
  endtask

  initial begin
    int np;
    vecs[0]  = '{5,   8'h18, 32'h1000, 16'h0800, -1, 8'h00, 0,  1'b0, 1'b0, 1'b1, 5'b00000, 5'b11111, 5};
    vecs[1]  = '{0,   8'h02, 32'h5000, 16'h0800, -1, 8'h00, 0,  1'b0, 1'b0, 1'b1, 5'b00000, 5'b11111, 0};
    vecs[2]  = '{5,   8'h18, 32'h1000, 16'h0800, 60, 8'h01, 0,  1'b0, 1'b0, 1'b0, 5'b00001, 5'b11111, 5};
    vecs[3]  = '{5,   8'h18, 32'h1000, 16'h0800, 24, 8'h01, 0,  1'b0, 1'b0, 1'b0, 5'b00011, 5'b11111, 5};
    vecs[4]  = '{5,   8'h18, 32'h1000, 16'h0800, 56, 8'h01, 0,  1'b0, 1'b0, 1'b0, 5'b00101, 5'b11111, 5};
    vecs[5]  = '{5,   8'h18, 32'h1000, 16'h86DD, -1, 8'h00, 0,  1'b0, 1'b0, 1'b0, 5'b01000, 5'b01000, 0};
    vecs[6]  = '{100, 8'h10, 32'h7777, 16'h0800, -1, 8'h00, 0,  1'b1, 1'b1, 1'b1, 5'b00000, 5'b11111, 100};
    vecs[7]  = '{5,   8'h18, 32'h1000, 16'h0800, -1, 8'h00, 41, 1'b0, 1'b0, 1'b0, 5'b10000, 5'b10000, 0};
    vecs[8]  = '{5,   8'h18, 32'h1000, 16'h0800, -1, 8'h00, 57, 1'b0, 1'b0, 1'b0, 5'b10000, 5'b10000, 3};
    vecs[9]  = '{10,  8'h18, 32'h2000, 16'h0800, -1, 8'h00, 0,  1'b0, 1'b0, 1'b1, 5'b00000, 5'b11111, 10};
    vecs[10] = '{10,  8'h18, 32'h2000, 16'h0800, -1, 8'h00, 67, 1'b0, 1'b0, 1'b0, 5'b10000, 5'b10000, 10};

    rst = 1'b1;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = 8'h00;
    s_axis.tlast  = 1'b0;
    m_axis.tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset s_tready", 64'(s_axis.tready), 64'd0);
    chk("reset m_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("reset pulses", 64'({pkt_valid, pkt_err}), 64'd0);
    chk("reset err_flags", 64'(err_flags), 64'd0);
    chk("reset o_pkt", 64'(|o_pkt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      build(vecs[i]);
      run_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Abort a frame by reset at byte 30, then a clean frame must give one pulse.
    build(vecs[0]);
    np = 0;
    for (int i = 0; i <= 30; i++) begin
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = fr[i];
      s_axis.tlast  = 1'b0;
      #1;
      if (pkt_valid || pkt_err) np++;
      @(negedge clk);
    end
    s_axis.tvalid = 1'b0;
    chk("mid-frame busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst abort busy", 64'(busy), 64'd0);
    chk("rst abort s_tready", 64'(s_axis.tready), 64'd0);
    @(negedge clk);
    #1;
    if (pkt_valid || pkt_err) np++;
    @(negedge clk);
    rst = 1'b0;
    chk("rst abort pulses", 64'(np), 64'd0);
    run_frame(vecs[0], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
